alu_issue_unit: RTL and testbench

Instruction issue/write-back sequencer that sits in front of the combinational `alu_verilog` block and drives it. It accepts 16-bit instruction words over a valid/ready stream and decodes them. It drives the ALU `opcode`/`a`/`b` from a 4-entry register file, then writes the ALU `c` result back and latches the ALU flags. It also supports immediate loads and a back-pressured register output port.

---
 rtl/alu_issue_unit.sv | 132 +++++++++++++
 tb/tb_alu_issue_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: fetch/decode/issue sequencer driving a combinational ALU.
// Owns a 4x16 register file, handles ALU ops, two-word immediate loads and a
// back-pressured register output port, and counts retired instructions.
module alu_issue_unit #(
  parameter int DATA_WIDTH = 16  // instruction format assumes 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_instr_valid,
  output logic                  o_instr_ready,
  input  logic [DATA_WIDTH-1:0] i_instr,
  output logic [DATA_WIDTH-1:0] o_alu_opcode,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  input  logic [DATA_WIDTH-1:0] i_alu_c,
  input  logic [3:0]            i_alu_flags,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [3:0]            o_flags,
  output logic                  o_illegal,
  output logic [15:0]           o_retired
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_IMM, S_EMIT} state_t;

  localparam logic [3:0] SEL_NOP = 4'h0;
  localparam logic [3:0] SEL_ALU = 4'h1;
  localparam logic [3:0] SEL_LDI = 4'h2;
  localparam logic [3:0] SEL_OUT = 4'h3;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] r_rf [4];
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [3:0]            r_flags;
  logic                  r_illegal;
  logic [15:0]           r_retired;

  logic [3:0] w_sel;
  logic [1:0] w_ra;
  logic [1:0] w_rb;
  logic [1:0] w_ir_rd;

  assign w_sel   = i_instr[15:12];
  assign w_ra    = i_instr[3:2];
  assign w_rb    = i_instr[1:0];
  assign w_ir_rd = r_ir[5:4];

  // Words are accepted only in FETCH/IMM; held low for the whole reset pulse.
  assign o_instr_ready = !i_reset && ((r_state == S_FETCH) || (r_state == S_IMM));

  // The opcode is the captured instruction word itself, shown only in EXEC so
  // the ALU sits on its default path otherwise.
  assign o_alu_opcode = (r_state == S_EXEC) ? r_ir : '0;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_flags      = r_flags;
  assign o_illegal    = r_illegal;
  assign o_retired    = r_retired;

  // Sequencer: decode, operand capture, write-back, output handshake, counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_FETCH;
      r_ir        <= '0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_flags     <= 4'b0001;
      r_illegal   <= 1'b0;
      r_retired   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_instr_valid) begin
            r_ir <= i_instr;
            case (w_sel)
              SEL_NOP: r_retired <= r_retired + 16'd1;
              SEL_ALU: begin
                // Operands are sampled here, so rd==ra/rb sees the old value.
                r_alu_a <= r_rf[w_ra];
                r_alu_b <= r_rf[w_rb];
                r_state <= S_EXEC;
              end
              SEL_LDI: r_state <= S_IMM;
              SEL_OUT: begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_rf[w_ra];
                r_state     <= S_EMIT;
              end
              default: r_illegal <= 1'b1;
            endcase
          end
        end
        S_EXEC: begin
          r_rf[w_ir_rd] <= i_alu_c;
          r_flags       <= i_alu_flags;
          r_retired     <= r_retired + 16'd1;
          r_alu_a       <= '0;
          r_alu_b       <= '0;
          r_state       <= S_FETCH;
        end
        S_IMM: begin
          if (i_instr_valid) begin
            r_rf[w_ir_rd] <= i_instr;
            r_retired     <= r_retired + 16'd1;
            r_state       <= S_FETCH;
          end
        end
        S_EMIT: begin
          // Register file cannot change here, so out_data holds while stalled.
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_retired   <= r_retired + 16'd1;
            r_state     <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: stand-in ALU, transaction-level model of the
// architectural state, per-cycle comparison plus literal anchor checks.
module tb_alu_issue_unit;

  logic        clk, reset;
  logic        instr_valid, instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_opcode, alu_a, alu_b, alu_c;
  logic [3:0]  alu_flags;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [3:0]  flags;
  logic        illegal;
  logic [15:0] retired;

  int n_chk = 0;
  int n_err = 0;

  alu_issue_unit #(.DATA_WIDTH(16)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_instr_valid(instr_valid), .o_instr_ready(instr_ready), .i_instr(instr),
    .o_alu_opcode(alu_opcode), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .i_alu_c(alu_c), .i_alu_flags(alu_flags),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_flags(flags), .o_illegal(illegal), .o_retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: op in [11:8]; 0 ADD,1 SUB,2 AND,3 OR,4 XOR, others give 0.
  // Flags are {0,0,C,Z}; C is carry-out for ADD and borrow for SUB.
  function automatic logic [19:0] alu_f(input logic [15:0] op, a, b);
    logic [16:0] t;
    logic [15:0] c;
    logic        cy;
    t = '0; c = '0; cy = 1'b0;
    case (op[11:8])
      4'd0: begin t = {1'b0, a} + {1'b0, b}; c = t[15:0]; cy = t[16]; end
      4'd1: begin c = a - b; cy = (a < b); end
      4'd2: c = a & b;
      4'd3: c = a | b;
      4'd4: c = a ^ b;
      default: c = '0;
    endcase
    return {2'b00, cy, (c == 16'd0), c};
  endfunction

  assign {alu_flags, alu_c} = alu_f(alu_opcode, alu_a, alu_b);

  // Architectural model and expected per-cycle outputs.
  logic [15:0] m_rf [4];
  logic [3:0]  m_flags;
  logic        m_ill, m_imm;
  logic [1:0]  m_rd;
  logic [15:0] m_ret;
  logic        e_ready, e_outv;
  logic [15:0] e_outd, e_op, e_a, e_b;
  logic [15:0] last_out;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_flags = 4'b0001; m_ill = 1'b0; m_imm = 1'b0; m_rd = 2'd0; m_ret = '0;
    e_ready = 1'b0; e_outv = 1'b0; e_outd = '0; e_op = '0; e_a = '0; e_b = '0;
  endtask

  // Compare every observable output against the model once per cycle.
  always @(negedge clk) begin
    chk("instr_ready", {15'd0, instr_ready}, {15'd0, e_ready});
    chk("out_valid",   {15'd0, out_valid},   {15'd0, e_outv});
    chk("out_data",    out_data,             e_outd);
    chk("flags",       {12'd0, flags},       {12'd0, m_flags});
    chk("illegal",     {15'd0, illegal},     {15'd0, m_ill});
    chk("retired",     retired,              m_ret);
    chk("alu_opcode",  alu_opcode,           e_op);
    chk("alu_a",       alu_a,                e_a);
    chk("alu_b",       alu_b,                e_b);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word; for ALU/OUT an illegal junk word stays valid while the
  // unit is busy, which must not be consumed.
  task automatic send(input logic [15:0] w, input int stall);
    logic [19:0] r;
    instr_valid = 1'b1; instr = w;
    @(posedge clk); #1;
    if (m_imm) begin
      m_rf[m_rd] = w; m_ret++; m_imm = 1'b0; instr_valid = 1'b0;
    end else begin
      case (w[15:12])
        4'h0: begin m_ret++; instr_valid = 1'b0; end
        4'h1: begin
          e_op = w; e_a = m_rf[w[3:2]]; e_b = m_rf[w[1:0]]; e_ready = 1'b0;
          instr = 16'h7000;
          @(posedge clk); #1;
          r = alu_f(w, e_a, e_b);
          m_rf[w[5:4]] = r[15:0]; m_flags = r[19:16]; m_ret++;
          e_op = '0; e_a = '0; e_b = '0; e_ready = 1'b1; instr_valid = 1'b0;
        end
        4'h2: begin m_imm = 1'b1; m_rd = w[5:4]; instr_valid = 1'b0; end
        4'h3: begin
          e_outv = 1'b1; e_outd = m_rf[w[3:2]]; e_ready = 1'b0;
          instr = 16'h7000;
          last_out = out_data;
          repeat (stall) begin @(posedge clk); #1; end
          out_ready = 1'b1;
          @(posedge clk); #1;
          out_ready = 1'b0; m_ret++;
          e_outv = 1'b0; e_outd = '0; e_ready = 1'b1; instr_valid = 1'b0;
        end
        default: begin m_ill = 1'b1; instr_valid = 1'b0; end
      endcase
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; out_ready = 1'b0; last_out = '0;
    model_reset();
    #1;
    chk("rst ready", {15'd0, instr_ready}, 16'd0);
    chk("rst flags", {12'd0, flags}, 16'h0001);
    chk("rst retired", retired, 16'd0);
    idle(2);
    reset = 1'b0; e_ready = 1'b1;
    idle(1);

    // Immediate loads then ADD.
    send(16'h2000, 0); idle(2); send(16'h0005, 0);
    send(16'h2010, 0); send(16'h0003, 0);
    send(16'h1021, 0);
    chk("add flags", {12'd0, flags}, 16'h0000);
    chk("add retired", retired, 16'd3);
    send(16'h3008, 0);
    chk("out R2", last_out, 16'h0008);

    // SUB with borrow, stalled OUT, SUB to zero.
    send(16'h1134, 0);
    chk("sub flags", {12'd0, flags}, 16'h0002);
    send(16'h300C, 5);
    chk("out R3", last_out, 16'hFFFE);
    send(16'h1100, 0);
    chk("sub zero flags", {12'd0, flags}, 16'h0001);

    // Reserved bits ignored; op 9 yields zero result with Z.
    send(16'h1041, 0);
    chk("add2 flags", {12'd0, flags}, 16'h0000);
    send(16'h1920, 0);
    chk("op9 flags", {12'd0, flags}, 16'h0001);

    // Back-to-back ALU words (rd==ra/rb reads old values).
    send(16'h1055, 0); send(16'h1201, 0); send(16'h1312, 0); send(16'h1033, 0);
    chk("b2b flags", {12'd0, flags}, 16'h0003);
    chk("b2b retired", retired, 16'd13);

    // Illegal word then NOP.
    send(16'h7000, 0);
    chk("illegal set", {15'd0, illegal}, 16'd1);
    chk("illegal retired", retired, 16'd13);
    send(16'h0000, 0);
    chk("nop retired", retired, 16'd14);

    // Reset while waiting for an immediate.
    send(16'h2030, 0); idle(1);
    #1 reset = 1'b1; model_reset();
    #1;
    chk("async ready", {15'd0, instr_ready}, 16'd0);
    chk("async illegal", {15'd0, illegal}, 16'd0);
    chk("async retired", retired, 16'd0);
    chk("async flags", {12'd0, flags}, 16'h0001);
    idle(2);
    reset = 1'b0; e_ready = 1'b1;
    send(16'h0000, 0);
    chk("post rst nop", retired, 16'd1);
    send(16'h300C, 0);
    chk("R3 after rst", last_out, 16'h0000);

    // Wrap the retire counter.
    for (int i = 0; i < 65534; i++) send(16'h0000, 0);
    chk("retired wrap", retired, 16'h0000);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
